// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
// Module : mmu_pkg
// Brief  : Shared state encoding, size defaults and lane-slice helper for the
//          systolic MMU feeder.
// Rev    : 1.0
// ============================================================================
package mmu_pkg;

   localparam int N_DEFAULT  = 4;
   localparam int DW_DEFAULT = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WT_FILL = 3'd1,
      ST_WT_LOAD = 3'd2,
      ST_STREAM  = 3'd3,
      ST_DRAIN   = 3'd4
   } feeder_state_e;

   // Lane 0 occupies the most-significant slice of every N*DW bus.
   function automatic int lane_lo(input int k, input int n, input int dw);
      return (n - 1 - k) * dw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mmu_skew_lane.sv
`default_nettype none
// ============================================================================
// Module : mmu_skew_lane
// Brief  : DEPTH-stage shift register with zero reset; one per array lane.
// Rev    : 1.0
// ============================================================================
module mmu_skew_lane #(
   parameter int DEPTH = 1,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din_i,
   output logic [DW-1:0] dout_o
);

   logic [DW-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mmu_feeder.sv
`default_nettype none
// ============================================================================
// Module : mmu_feeder
// Brief  : Buffers N weight rows, bursts them into the systolic MMU, then
//          streams diagonally skewed activations, drains and pulses done.
//          Optional FEEDER_TAG_EN adds a skewed per-lane valid tag (row_tag).
// Rev    : 1.0
// ============================================================================
module mmu_feeder
   import mmu_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int DW = DW_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [N*DW-1:0] wt_in,
   input  logic            wt_valid,
   output logic            wt_ready,
   input  logic [N*DW-1:0] act_in,
   input  logic            act_valid,
   input  logic            act_last,
   output logic            act_ready,
   output logic            control,
   output logic [N*DW-1:0] wt_arr,
   output logic [N*DW-1:0] data_arr,
`ifdef FEEDER_TAG_EN
   output logic [N-1:0]    row_tag,
`endif
   output logic            busy,
   output logic            done
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] C_LAST       = IW'(N - 1);
   localparam logic [IW-1:0] C_DRAIN_LAST = IW'((N > 1) ? N - 2 : 0);

   feeder_state_e     state_q;
   logic [IW-1:0]     cnt_q;
   logic [N*DW-1:0]   wt_buf_q [N];
   logic              wt_ready_q;
   logic              act_ready_q;
   logic              control_q;
   logic [N*DW-1:0]   wt_arr_q;
   logic              busy_q;
   logic              done_q;

   logic              wt_acc;
   logic              act_acc;
   logic [N*DW-1:0]   skew_in;

   assign wt_acc  = wt_valid & wt_ready_q;
   assign act_acc = act_valid & act_ready_q;

   // The array cannot stall, so a non-accept cycle feeds a zero bubble.
   assign skew_in = act_acc ? act_in : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         wt_ready_q  <= 1'b0;
         act_ready_q <= 1'b0;
         control_q   <= 1'b0;
         wt_arr_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < N; i++) begin
            wt_buf_q[i] <= '0;
         end
      end else begin
         done_q    <= 1'b0;
         control_q <= 1'b0;
         wt_arr_q  <= '0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_WT_FILL;
                  busy_q     <= 1'b1;
                  wt_ready_q <= 1'b1;
                  cnt_q      <= '0;
               end
            end
            ST_WT_FILL: begin
               if (wt_acc) begin
                  wt_buf_q[cnt_q] <= wt_in;
                  if (cnt_q == C_LAST) begin
                     state_q    <= ST_WT_LOAD;
                     wt_ready_q <= 1'b0;
                     cnt_q      <= '0;
                  end else begin
                     cnt_q <= cnt_q + IW'(1);
                  end
               end
            end
            ST_WT_LOAD: begin
               control_q <= 1'b1;
               wt_arr_q  <= wt_buf_q[cnt_q];
               if (cnt_q == C_LAST) begin
                  state_q     <= ST_STREAM;
                  act_ready_q <= 1'b1;
                  cnt_q       <= '0;
               end else begin
                  cnt_q <= cnt_q + IW'(1);
               end
            end
            ST_STREAM: begin
               if (act_acc && act_last) begin
                  act_ready_q <= 1'b0;
                  cnt_q       <= '0;
                  // A single-lane array has no skew left to drain.
                  if (N == 1) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (cnt_q == C_DRAIN_LAST) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + IW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_lane
      mmu_skew_lane #(
         .DEPTH (k + 1),
         .DW    (DW)
      ) u_skew (
         .clk    (clk),
         .rst_n  (rst_n),
         .din_i  (skew_in[lane_lo(k, N, DW) +: DW]),
         .dout_o (data_arr[lane_lo(k, N, DW) +: DW])
      );
`ifdef FEEDER_TAG_EN
      mmu_skew_lane #(
         .DEPTH (k + 1),
         .DW    (1)
      ) u_tag (
         .clk    (clk),
         .rst_n  (rst_n),
         .din_i  (act_acc),
         .dout_o (row_tag[k])
      );
`endif
   end

   assign wt_ready  = wt_ready_q;
   assign act_ready = act_ready_q;
   assign control   = control_q;
   assign wt_arr    = wt_arr_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mmu_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_mmu_feeder
// Brief  : Directed self-checking bench for mmu_feeder (N=4, DW=8).
// Rev    : 1.0
// ============================================================================
module tb_mmu_feeder;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int L  = 12;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [N*DW-1:0] wt_in;
   logic            wt_valid;
   logic            wt_ready;
   logic [N*DW-1:0] act_in;
   logic            act_valid;
   logic            act_last;
   logic            act_ready;
   logic            control;
   logic [N*DW-1:0] wt_arr;
   logic [N*DW-1:0] data_arr;
   logic            busy;
   logic            done;
`ifdef FEEDER_TAG_EN
   logic [N-1:0]    row_tag;
`endif

   int checks = 0;
   int errors = 0;

   mmu_feeder #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .wt_in     (wt_in),
      .wt_valid  (wt_valid),
      .wt_ready  (wt_ready),
      .act_in    (act_in),
      .act_valid (act_valid),
      .act_last  (act_last),
      .act_ready (act_ready),
      .control   (control),
      .wt_arr    (wt_arr),
      .data_arr  (data_arr),
`ifdef FEEDER_TAG_EN
      .row_tag   (row_tag),
`endif
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_control"},   32'(control),   32'd0);
      chk({tag, "_wt_arr"},    wt_arr,         32'd0);
      chk({tag, "_data_arr"},  data_arr,       32'd0);
      chk({tag, "_wt_ready"},  32'(wt_ready),  32'd0);
      chk({tag, "_act_ready"}, 32'(act_ready), 32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_done"},      32'(done),      32'd0);
   endtask

   logic [31:0] wts [N] = '{32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403};

   // Start a job, push the four weight rows and follow the control burst.
   task automatic load_job(input bit poke_start);
      int n;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("wt_ready_fill", 32'(wt_ready), 32'd1);
      for (int i = 0; i < N; i++) begin
         wt_in    = wts[i];
         wt_valid = 1'b1;
         start    = poke_start && (i == 1);
         tick();
      end
      wt_valid = 1'b0;
      start    = 1'b0;
      wt_in    = $urandom;
      chk("wt_ready_drop", 32'(wt_ready), 32'd0);
      n = 0;
      while (!control && n < 6) begin
         tick();
         n++;
      end
      chk("control_rise", 32'(control), 32'd1);
      for (int i = 0; i < N; i++) begin
         chk("load_control", 32'(control), 32'd1);
         chk("load_wt_arr", wt_arr, wts[i]);
         chk("load_data_zero", data_arr, 32'd0);
         tick();
      end
      chk("control_fall", 32'(control), 32'd0);
      chk("wt_arr_clear", wt_arr, 32'd0);
   endtask

   task automatic stream(input string tag, input int ncyc, input bit vld [L],
                         input logic [31:0] vin [L], input bit lst [L],
                         input logic [31:0] exp_d [L], input int done_at,
                         input bit poke_start);
      int n;
      n = 0;
      while (!act_ready && n < 8) begin
         tick();
         n++;
      end
      chk({tag, "_act_ready"}, 32'(act_ready), 32'd1);
      for (int j = 0; j < ncyc; j++) begin
         act_valid = vld[j];
         act_in    = vld[j] ? vin[j] : $urandom;
         act_last  = lst[j];
         start     = poke_start && (j == 1);
         tick();
         chk({tag, "_data"}, data_arr, exp_d[j]);
         chk({tag, "_done"}, 32'(done), 32'(j == done_at));
         chk({tag, "_busy"}, 32'(busy), 32'(j < done_at));
`ifdef FEEDER_TAG_EN
         begin
            logic [N-1:0] etag;
            etag = '0;
            for (int k = 0; k < N; k++) begin
               if (j - k >= 0) etag[k] = vld[j-k];
            end
            chk({tag, "_row_tag"}, 32'(row_tag), 32'(etag));
         end
`endif
      end
      act_valid = 1'b0;
      act_last  = 1'b0;
      start     = 1'b0;
   endtask

   bit          v3 [L] = '{1,1,1,1,0,0,0,0,0,0,0,0};
   bit          l3 [L] = '{0,0,0,1,0,0,0,0,0,0,0,0};
   logic [31:0] i3 [L] = '{32'h01020506, 32'h02030607, 32'h03040708, 32'h04050809,
                           0, 0, 0, 0, 0, 0, 0, 0};
   logic [31:0] e3 [L] = '{32'h01000000, 32'h02020000, 32'h03030500, 32'h04040606,
                           32'h00050707, 32'h00000808, 32'h00000009, 32'h00000000,
                           0, 0, 0, 0};

   bit          v4 [L] = '{1,1,0,1,1,0,0,0,0,0,0,0};
   bit          l4 [L] = '{0,0,0,0,1,0,0,0,0,0,0,0};
   logic [31:0] i4 [L] = '{32'h01020506, 32'h02030607, 0, 32'h03040708, 32'h04050809,
                           0, 0, 0, 0, 0, 0, 0};
   logic [31:0] e4 [L] = '{32'h01000000, 32'h02020000, 32'h00030500, 32'h03000606,
                           32'h04040007, 32'h00050700, 32'h00000808, 32'h00000009,
                           32'h00000000, 0, 0, 0};

   initial begin
      rst_n     = 1'b0;
      start     = 1'($urandom);
      wt_in     = $urandom;
      wt_valid  = 1'($urandom);
      act_in    = $urandom;
      act_valid = 1'($urandom);
      act_last  = 1'($urandom);
      tick();
      tick();
      chk_outputs_zero("reset");

      start = 1'b0; wt_valid = 1'b0; act_valid = 1'b0; act_last = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Plain job: back-to-back stream.
      load_job(1'b0);
      stream("s3", 8, v3, i3, l3, e3, 6, 1'b0);
      tick();
      chk("idle_after_s3", 32'(busy), 32'd0);

      // Job with a one-cycle bubble between vectors 2 and 3.
      load_job(1'b0);
      stream("s4", 9, v4, i4, l4, e4, 7, 1'b0);

      // Abort in the middle of streaming.
      load_job(1'b0);
      act_in = 32'h01020506; act_valid = 1'b1; tick();
      act_in = 32'h02030607; tick();
      act_valid = 1'b0;
      chk("pre_abort_data", data_arr, 32'h02020000);
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("abort_async");
      tick();
      chk("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_abort_done", 32'(done), 32'd0);
         chk("post_abort_data", data_arr, 32'd0);
      end

      // Fresh job after abort with start poked while busy.
      load_job(1'b1);
      stream("s6", 8, v3, i3, l3, e3, 6, 1'b1);
      tick();
      chk("final_idle_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
